// File: rtl/axi_txn_budget_tracker.sv
// axi_txn_budget_tracker: per-ID outstanding-transaction budget monitor.
// Each ID owns a small ring of down-counting budget slots. A timeout,
// unexpected response or overflow trips the FSM, which holds irq/reset
// request until clr_i. Optional build macro: TXN_TRACKER_STALL_ON_FULL_EN
// (back-pressure a full ID via stall_o instead of reporting overflow).

// One ID's ring of budget slots plus its local error detection.
module axi_txn_budget_id_q #(
  parameter int TxnsPerId = 2,
  parameter int CntWidth  = 8,
  parameter int OccW      = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                flush_i,
  input  logic                tick_i,
  input  logic                enq_i,
  input  logic                rsp_hs_i,
  input  logic                rsp_last_i,
  input  logic [CntWidth-1:0] budget_i,
  output logic [OccW-1:0]     occ_o,
  output logic                stall_o,
  output logic                timeout_o,
  output logic                unexp_o,
  output logic                ovf_o
);
  localparam int PtrW = (TxnsPerId > 1) ? $clog2(TxnsPerId) : 1;

  logic [PtrW-1:0]                    head_q, tail_q;
  logic [OccW-1:0]                    occ_q;
  logic [TxnsPerId-1:0]               vld_q;
  logic [TxnsPerId-1:0][CntWidth-1:0] cnt_q;
  logic                               full, deq, blocked, do_enq;
  logic [CntWidth-1:0]                load_val;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(TxnsPerId - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign occ_o   = occ_q;
  assign full    = (occ_q == OccW'(TxnsPerId));
  // Only the last beat retires a transaction; any beat on an empty ID is bogus.
  assign deq     = rsp_hs_i & rsp_last_i & (occ_q != '0);
  assign unexp_o = rsp_hs_i & (occ_q == '0);
  // A same-cycle dequeue frees the head slot, so the ID is not full for it.
  assign blocked = enq_i & full & ~deq;
  assign do_enq  = enq_i & ~blocked;
  // The load cycle's tick counts, so budget B reaches zero B cycles later.
  assign load_val = (tick_i && budget_i != '0) ? budget_i - CntWidth'(1) : budget_i;

`ifdef TXN_TRACKER_STALL_ON_FULL_EN
  assign stall_o = full & ~deq;
  assign ovf_o   = 1'b0;
`else
  assign stall_o = 1'b0;
  assign ovf_o   = blocked;
`endif

  // Expired slot that is not being retired this very cycle.
  always_comb begin
    timeout_o = 1'b0;
    for (int i = 0; i < TxnsPerId; i++)
      if (vld_q[i] && cnt_q[i] == '0 && !(deq && head_q == PtrW'(i))) timeout_o = 1'b1;
  end

  // Slot counters, valid bits, pointers and occupancy.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
      vld_q  <= '0;
      cnt_q  <= '0;
    end else if (flush_i) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
      vld_q  <= '0;
    end else begin
      for (int i = 0; i < TxnsPerId; i++)
        if (tick_i && vld_q[i] && cnt_q[i] != '0) cnt_q[i] <= cnt_q[i] - CntWidth'(1);
      if (deq) begin
        vld_q[head_q] <= 1'b0;
        head_q        <= ptr_inc(head_q);
      end
      // Enqueue last: on a full ring head==tail and the new entry must win.
      if (do_enq) begin
        vld_q[tail_q] <= 1'b1;
        cnt_q[tail_q] <= load_val;
        tail_q        <= ptr_inc(tail_q);
      end
      if (do_enq && !deq)      occ_q <= occ_q + OccW'(1);
      else if (!do_enq && deq) occ_q <= occ_q - OccW'(1);
    end
  end
endmodule

module axi_txn_budget_tracker #(
  parameter int IdWidth      = 2,
  parameter int TxnsPerId    = 2,
  parameter int CntWidth     = 8,
  parameter int PrescalerDiv = 1
) (
  input  logic                                     clk_i,
  input  logic                                     rst_i,
  input  logic                                     en_i,
  input  logic                                     req_valid_i,
  input  logic                                     req_ready_i,
  input  logic [IdWidth-1:0]                       req_id_i,
  input  logic                                     rsp_valid_i,
  input  logic                                     rsp_ready_i,
  input  logic [IdWidth-1:0]                       rsp_id_i,
  input  logic                                     rsp_last_i,
  input  logic [CntWidth-1:0]                      budget_i,
  input  logic                                     clr_i,
  output logic                                     stall_o,
  output logic                                     irq_o,
  output logic                                     rst_req_o,
  output logic [1:0]                               err_kind_o,
  output logic [IdWidth-1:0]                       err_id_o,
  output logic [IdWidth+$clog2(TxnsPerId+1)-1:0]   outstanding_o
);
  localparam int NumIds = 1 << IdWidth;
  localparam int OccW   = $clog2(TxnsPerId + 1);
  localparam int OutW   = IdWidth + OccW;
  localparam int PreW   = (PrescalerDiv > 1) ? $clog2(PrescalerDiv) : 1;

  typedef enum logic [1:0] {S_RUN, S_TRIP, S_FLUSH} state_e;
  state_e state_q, state_d;

  logic                         run, flush, tick, req_hs, rsp_hs;
  logic [PreW-1:0]              presc_q;
  logic [NumIds-1:0][OccW-1:0]  occ;
  logic [NumIds-1:0]            stall_id, timeout, unexp, ovf;
  logic [1:0]                   kind_d;
  logic [IdWidth-1:0]           id_d;

  assign run    = (state_q == S_RUN);
  assign flush  = (state_q == S_FLUSH);
  assign req_hs = req_valid_i & req_ready_i & en_i & run;
  assign rsp_hs = rsp_valid_i & rsp_ready_i & run;
  assign tick   = en_i & run & (presc_q == PreW'(PrescalerDiv - 1));

  // Prescaler: free-runs while enabled, restarts on flush.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)      presc_q <= '0;
    else if (flush) presc_q <= '0;
    else if (en_i)  presc_q <= (presc_q == PreW'(PrescalerDiv - 1)) ? '0 : presc_q + PreW'(1);
  end

  for (genvar g = 0; g < NumIds; g++) begin : g_id
    axi_txn_budget_id_q #(
      .TxnsPerId (TxnsPerId),
      .CntWidth  (CntWidth),
      .OccW      (OccW)
    ) u_q (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .flush_i    (flush),
      .tick_i     (tick),
      .enq_i      (req_hs & (req_id_i == IdWidth'(g))),
      .rsp_hs_i   (rsp_hs & (rsp_id_i == IdWidth'(g))),
      .rsp_last_i (rsp_last_i),
      .budget_i   (budget_i),
      .occ_o      (occ[g]),
      .stall_o    (stall_id[g]),
      .timeout_o  (timeout[g]),
      .unexp_o    (unexp[g]),
      .ovf_o      (ovf[g])
    );
  end

  assign stall_o = req_valid_i & stall_id[req_id_i];

  // Error arbitration: later loops override earlier ones, descending index
  // lets the lowest ID win inside each kind.
  always_comb begin
    kind_d = 2'b00;
    id_d   = '0;
    for (int i = NumIds - 1; i >= 0; i--)
      if (timeout[i]) begin kind_d = 2'b01; id_d = IdWidth'(i); end
    for (int i = NumIds - 1; i >= 0; i--)
      if (unexp[i])   begin kind_d = 2'b10; id_d = IdWidth'(i); end
    for (int i = NumIds - 1; i >= 0; i--)
      if (ovf[i])     begin kind_d = 2'b11; id_d = IdWidth'(i); end
  end

  // FSM state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= S_RUN;
    else       state_q <= state_d;
  end

  // FSM next state: trip on any error, wait for clear, flush for one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN:   if (kind_d != 2'b00) state_d = S_TRIP;
      S_TRIP:  if (clr_i) state_d = S_FLUSH;
      S_FLUSH: state_d = S_RUN;
      default: state_d = S_RUN;
    endcase
  end

  // Latch the first error seen in RUN; drop it as the flush completes.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_kind_o <= 2'b00;
      err_id_o   <= '0;
    end else if (run && kind_d != 2'b00) begin
      err_kind_o <= kind_d;
      err_id_o   <= id_d;
    end else if (flush) begin
      err_kind_o <= 2'b00;
      err_id_o   <= '0;
    end
  end

  assign irq_o     = ~run;
  assign rst_req_o = (state_q == S_TRIP);

  // Total tracked transactions across all IDs.
  always_comb begin
    outstanding_o = '0;
    for (int i = 0; i < NumIds; i++) outstanding_o = outstanding_o + OutW'(occ[i]);
  end
endmodule

// File: tb/tb_axi_txn_budget_tracker.sv
// Directed bench for axi_txn_budget_tracker: a PrescalerDiv=1 instance for
// most scenarios and a PrescalerDiv=4 instance sharing the same inputs for
// the prescaled timeout.
module tb_axi_txn_budget_tracker;
  logic       clk = 1'b0;
  logic       rst, en, req_valid, req_ready, rsp_valid, rsp_ready, rsp_last, clr;
  logic [1:0] req_id, rsp_id;
  logic [7:0] budget;

  logic       stall, irq, rst_req;
  logic [1:0] err_kind, err_id;
  logic [3:0] outstanding;
  logic       stall4, irq4, rst_req4;
  logic [1:0] err_kind4, err_id4;
  logic [3:0] outstanding4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axi_txn_budget_tracker #(.IdWidth(2), .TxnsPerId(2), .CntWidth(8), .PrescalerDiv(1)) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en),
    .req_valid_i(req_valid), .req_ready_i(req_ready), .req_id_i(req_id),
    .rsp_valid_i(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_id_i(rsp_id), .rsp_last_i(rsp_last),
    .budget_i(budget), .clr_i(clr),
    .stall_o(stall), .irq_o(irq), .rst_req_o(rst_req),
    .err_kind_o(err_kind), .err_id_o(err_id), .outstanding_o(outstanding)
  );

  axi_txn_budget_tracker #(.IdWidth(2), .TxnsPerId(2), .CntWidth(8), .PrescalerDiv(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .en_i(en),
    .req_valid_i(req_valid), .req_ready_i(req_ready), .req_id_i(req_id),
    .rsp_valid_i(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_id_i(rsp_id), .rsp_last_i(rsp_last),
    .budget_i(budget), .clr_i(clr),
    .stall_o(stall4), .irq_o(irq4), .rst_req_o(rst_req4),
    .err_kind_o(err_kind4), .err_id_o(err_id4), .outstanding_o(outstanding4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rst_pulse();
    rst = 1'b1;
    step(1);
    rst = 1'b0;
  endtask

  task automatic clear_trip();
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    step(1);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; clr = 1'b0;
    req_valid = 1'b0; req_ready = 1'b1; req_id = '0; budget = '0;
    rsp_valid = 1'b0; rsp_ready = 1'b1; rsp_id = '0; rsp_last = 1'b1;
    step(2);
    chk("rst_irq",     32'(irq), 0);
    chk("rst_rst_req", 32'(rst_req), 0);
    chk("rst_kind",    32'(err_kind), 0);
    chk("rst_id",      32'(err_id), 0);
    chk("rst_outst",   32'(outstanding), 0);
    chk("rst_stall",   32'(stall), 0);
    rst = 1'b0;
    step(1);

    // Prescaled timeout: budget 3, divide-by-4, prescaler at phase 0.
    en = 1'b1; req_valid = 1'b1; req_id = 2'd0; budget = 8'd3;
    step(1);
    req_valid = 1'b0;
    step(11);
    chk("div4_irq_t12", 32'(irq4), 0);
    step(1);
    chk("div4_irq_t13", 32'(irq4), 1);
    chk("div4_kind",    32'(err_kind4), 1);
    rst_pulse();

    // Budget 5 on ID 1, response three cycles later: no error.
    req_valid = 1'b1; req_id = 2'd1; budget = 8'd5;
    step(1);
    req_valid = 1'b0;
    chk("t1_outst_1", 32'(outstanding), 1);
    step(2);
    rsp_valid = 1'b1; rsp_id = 2'd1;
    step(1);
    rsp_valid = 1'b0;
    chk("t1_outst_0", 32'(outstanding), 0);
    step(8);
    chk("t1_irq", 32'(irq), 0);

    // Budget 5 on ID 2, never answered: irq six cycles after enqueue.
    req_valid = 1'b1; req_id = 2'd2; budget = 8'd5;
    step(1);
    req_valid = 1'b0;
    step(4);
    chk("t2_irq_t5", 32'(irq), 0);
    step(1);
    chk("t2_irq_t6",  32'(irq), 1);
    chk("t2_rst_req", 32'(rst_req), 1);
    chk("t2_kind",    32'(err_kind), 1);
    chk("t2_id",      32'(err_id), 2);
    step(3);
    chk("t2_sticky", 32'(irq), 1);
    clear_trip();
    chk("t2_clr_irq",     32'(irq), 0);
    chk("t2_clr_rst_req", 32'(rst_req), 0);
    chk("t2_clr_kind",    32'(err_kind), 0);
    chk("t2_clr_id",      32'(err_id), 0);
    chk("t2_clr_outst",   32'(outstanding), 0);

    // Response on ID 3 with nothing outstanding.
    rsp_valid = 1'b1; rsp_id = 2'd3;
    chk("t3_irq_pre", 32'(irq), 0);
    step(1);
    rsp_valid = 1'b0;
    chk("t3_irq",  32'(irq), 1);
    chk("t3_kind", 32'(err_kind), 2);
    chk("t3_id",   32'(err_id), 3);
    clear_trip();

    // Zero budget on ID 3 expires the cycle after the load.
    req_valid = 1'b1; req_id = 2'd3; budget = 8'd0;
    step(1);
    req_valid = 1'b0;
    chk("b0_irq_t1", 32'(irq), 0);
    step(1);
    chk("b0_irq_t2", 32'(irq), 1);
    chk("b0_kind",   32'(err_kind), 1);
    chk("b0_id",     32'(err_id), 3);
    rst_pulse();

    // Three back-to-back enqueues on ID 0 with two slots.
    req_valid = 1'b1; req_id = 2'd0; budget = 8'd20;
    step(2);
`ifdef TXN_TRACKER_STALL_ON_FULL_EN
    chk("t4_stall", 32'(stall), 1);
`else
    chk("t4_stall", 32'(stall), 0);
`endif
    step(1);
    req_valid = 1'b0;
    chk("t4_outst", 32'(outstanding), 2);
`ifdef TXN_TRACKER_STALL_ON_FULL_EN
    chk("t4_irq", 32'(irq), 0);
`else
    chk("t4_irq",  32'(irq), 1);
    chk("t4_kind", 32'(err_kind), 3);
    chk("t4_id",   32'(err_id), 0);
`endif
    rst_pulse();

    // Fill ID 1, then enqueue and retire on it in the same cycle.
    req_valid = 1'b1; req_id = 2'd1; budget = 8'd50;
    step(2);
    rsp_valid = 1'b1; rsp_id = 2'd1;
    chk("t5_stall_swap", 32'(stall), 0);
    step(1);
    req_valid = 1'b0; rsp_valid = 1'b0;
    chk("t5_outst", 32'(outstanding), 2);
    chk("t5_irq",   32'(irq), 0);

    // ID 0 times out in the same cycle ID 1 overflows.
    req_valid = 1'b1; req_id = 2'd0; budget = 8'd2;
    step(1);
    req_valid = 1'b0;
    step(1);
    req_valid = 1'b1; req_id = 2'd1; budget = 8'd50;
    step(1);
    req_valid = 1'b0;
    chk("t6_irq", 32'(irq), 1);
`ifdef TXN_TRACKER_STALL_ON_FULL_EN
    chk("t6_kind", 32'(err_kind), 1);
    chk("t6_id",   32'(err_id), 0);
`else
    chk("t6_kind", 32'(err_kind), 3);
    chk("t6_id",   32'(err_id), 1);
`endif

    // Asynchronous reset while tripped.
    rst = 1'b1;
    #1;
    chk("arst_irq",     32'(irq), 0);
    chk("arst_rst_req", 32'(rst_req), 0);
    chk("arst_kind",    32'(err_kind), 0);
    chk("arst_outst",   32'(outstanding), 0);
    rst = 1'b0;
    step(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
